// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with ALU operand selection and hazard stall.
// Define EX_OPERAND_FORWARD_EN to enable EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic [1:0]      id_asel_i,
  input  logic            id_bsel_i,
  input  logic [3:0]      id_aluctrl_i,
  input  logic            id_regwrite_i,
  input  logic            id_memread_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [4:0]      mem_rd_i,
  input  logic            mem_regwrite_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic [4:0]      wb_rd_i,
  input  logic            wb_regwrite_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] ALUop1_o,
  output logic [XLEN-1:0] ALUop2_o,
  output logic [3:0]      ALUctrl_o,
  output logic            ex_valid_o,
  output logic            ex_regwrite_o,
  output logic            ex_memread_o,
  output logic [4:0]      ex_rd_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic            stall_o
);

  localparam logic [1:0] ASEL_RS1 = 2'b00;
  localparam logic [1:0] ASEL_PC  = 2'b01;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [1:0]      asel;
    logic            bsel;
    logic [3:0]      aluctrl;
    logic            regwrite;
    logic            memread;
  } entry_t;

  entry_t          entry_q;
  entry_t          entry_d;
  logic            load_use;
  logic            raw_hazard;
  logic            stall;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // A load in EX cannot supply its data in time for a dependent instruction in decode.
  always_comb begin
    load_use = entry_q.valid && entry_q.memread && (entry_q.rd != 5'd0) &&
               ((entry_q.rd == id_rs1_i) || (entry_q.rd == id_rs2_i));
  end

`ifdef EX_OPERAND_FORWARD_EN
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      src,
    input logic [XLEN-1:0] reg_data,
    input logic [4:0]      mem_rd,
    input logic            mem_we,
    input logic [XLEN-1:0] mem_val,
    input logic [4:0]      wb_rd,
    input logic            wb_we,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] result;
    result = reg_data;
    if (src != 5'd0) begin
      if (mem_we && (mem_rd == src)) begin
        result = mem_val;
      end else if (wb_we && (wb_rd == src)) begin
        result = wb_val;
      end
    end
    return result;
  endfunction

  always_comb begin
    raw_hazard = 1'b0;
    rs1_fwd = fwd_sel(entry_q.rs1, entry_q.rs1_data, mem_rd_i, mem_regwrite_i,
                      mem_result_i, wb_rd_i, wb_regwrite_i, wb_data_i);
    rs2_fwd = fwd_sel(entry_q.rs2, entry_q.rs2_data, mem_rd_i, mem_regwrite_i,
                      mem_result_i, wb_rd_i, wb_regwrite_i, wb_data_i);
  end
`else
  logic rs1_busy;
  logic rs2_busy;
  logic unused_fwd;

  // Without forwarding, any pending writer in EX or MEM of a decode source must drain first.
  always_comb begin
    rs1_busy = (id_rs1_i != 5'd0) &&
               ((entry_q.valid && entry_q.regwrite && (entry_q.rd == id_rs1_i)) ||
                (mem_regwrite_i && (mem_rd_i == id_rs1_i)));
    rs2_busy = (id_rs2_i != 5'd0) &&
               ((entry_q.valid && entry_q.regwrite && (entry_q.rd == id_rs2_i)) ||
                (mem_regwrite_i && (mem_rd_i == id_rs2_i)));
    raw_hazard = rs1_busy || rs2_busy;
    rs1_fwd = entry_q.rs1_data;
    rs2_fwd = entry_q.rs2_data;
  end

  assign unused_fwd = ^{mem_result_i, wb_rd_i, wb_regwrite_i, wb_data_i,
                        entry_q.rs1, entry_q.rs2};
`endif

  assign stall   = rst_ni && id_valid_i && !flush_i && (load_use || raw_hazard);
  assign stall_o = stall;

  // Hold wins over stall so a frozen pipeline keeps its instruction instead of bubbling it.
  always_comb begin
    entry_d = entry_q;
    if (flush_i) begin
      entry_d.valid    = 1'b0;
      entry_d.regwrite = 1'b0;
      entry_d.memread  = 1'b0;
    end else if (hold_i) begin
      entry_d = entry_q;
    end else if (stall) begin
      entry_d.valid    = 1'b0;
      entry_d.regwrite = 1'b0;
      entry_d.memread  = 1'b0;
    end else begin
      entry_d.valid    = id_valid_i;
      entry_d.pc       = id_pc_i;
      entry_d.imm      = id_imm_i;
      entry_d.rs1_data = id_rs1_data_i;
      entry_d.rs2_data = id_rs2_data_i;
      entry_d.rs1      = id_rs1_i;
      entry_d.rs2      = id_rs2_i;
      entry_d.rd       = id_rd_i;
      entry_d.asel     = id_asel_i;
      entry_d.bsel     = id_bsel_i;
      entry_d.aluctrl  = id_aluctrl_i;
      entry_d.regwrite = id_regwrite_i && id_valid_i;
      entry_d.memread  = id_memread_i && id_valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  always_comb begin
    ALUop1_o  = '0;
    ALUop2_o  = '0;
    ALUctrl_o = 4'b0000;
    if (entry_q.valid) begin
      case (entry_q.asel)
        ASEL_RS1: ALUop1_o = rs1_fwd;
        ASEL_PC:  ALUop1_o = entry_q.pc;
        default:  ALUop1_o = '0;
      endcase
      ALUop2_o  = entry_q.bsel ? entry_q.imm : rs2_fwd;
      ALUctrl_o = entry_q.aluctrl;
    end
  end

  assign ex_valid_o      = entry_q.valid;
  assign ex_regwrite_o   = entry_q.regwrite;
  assign ex_memread_o    = entry_q.memread;
  assign ex_rd_o         = entry_q.rd;
  assign ex_store_data_o = rs2_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scenarios plus randomized cycles checked against an
// instruction-level model of the ID/EX entry (works with or without EX_OPERAND_FORWARD_EN).
module tb_ex_operand_stage;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i;
  logic [4:0]      id_rs1_i, id_rs2_i, id_rd_i;
  logic [1:0]      id_asel_i;
  logic            id_bsel_i;
  logic [3:0]      id_aluctrl_i;
  logic            id_regwrite_i, id_memread_i;
  logic            hold_i, flush_i;
  logic [4:0]      mem_rd_i, wb_rd_i;
  logic            mem_regwrite_i, wb_regwrite_i;
  logic [XLEN-1:0] mem_result_i, wb_data_i;
  logic [XLEN-1:0] ALUop1_o, ALUop2_o, ex_store_data_o;
  logic [3:0]      ALUctrl_o;
  logic            ex_valid_o, ex_regwrite_o, ex_memread_o, stall_o;
  logic [4:0]      ex_rd_o;

  ex_operand_stage #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_imm_i(id_imm_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_asel_i(id_asel_i), .id_bsel_i(id_bsel_i), .id_aluctrl_i(id_aluctrl_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .hold_i(hold_i), .flush_i(flush_i),
    .mem_rd_i(mem_rd_i), .mem_regwrite_i(mem_regwrite_i), .mem_result_i(mem_result_i),
    .wb_rd_i(wb_rd_i), .wb_regwrite_i(wb_regwrite_i), .wb_data_i(wb_data_i),
    .ALUop1_o(ALUop1_o), .ALUop2_o(ALUop2_o), .ALUctrl_o(ALUctrl_o),
    .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
    .ex_rd_o(ex_rd_o), .ex_store_data_o(ex_store_data_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  // The instruction currently sitting in EX, as the reference model sees it.
  typedef struct {
    bit        valid;
    bit [31:0] pc, imm, r1d, r2d;
    bit [4:0]  rs1, rs2, rd;
    bit [1:0]  asel;
    bit        bsel;
    bit [3:0]  ctrl;
    bit        rw, mr;
  } modelEntry_t;

  modelEntry_t model;
  int total = 0;
  int bad = 0;
  logic [31:0] heldOp1, heldOp2;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic modelEntry_t emptyEntry();
    modelEntry_t e;
    e = '{valid: 0, pc: 0, imm: 0, r1d: 0, r2d: 0, rs1: 0, rs2: 0, rd: 0,
          asel: 0, bsel: 0, ctrl: 0, rw: 0, mr: 0};
    return e;
  endfunction

  // Value the ALU should see for a source register of the EX instruction.
  function automatic bit [31:0] operandValue(input bit [4:0] src, input bit [31:0] regVal);
`ifdef EX_OPERAND_FORWARD_EN
    if (src != 0 && mem_regwrite_i && mem_rd_i == src) return mem_result_i;
    if (src != 0 && wb_regwrite_i && wb_rd_i == src) return wb_data_i;
`endif
    return regVal;
  endfunction

  function automatic bit readsPending(input bit [4:0] src);
`ifdef EX_OPERAND_FORWARD_EN
    return 1'b0;
`else
    if (src == 0) return 1'b0;
    return (model.valid && model.rw && model.rd == src) ||
           (mem_regwrite_i && mem_rd_i == src);
`endif
  endfunction

  function automatic bit expStall();
    bit loadUse;
    loadUse = model.valid && model.mr && model.rd != 0 &&
              (model.rd == id_rs1_i || model.rd == id_rs2_i);
    return rst_ni && id_valid_i && !flush_i &&
           (loadUse || readsPending(id_rs1_i) || readsPending(id_rs2_i));
  endfunction

  function automatic bit [31:0] expOp1();
    if (!model.valid) return 0;
    if (model.asel == 2'd0) return operandValue(model.rs1, model.r1d);
    if (model.asel == 2'd1) return model.pc;
    return 0;
  endfunction

  function automatic bit [31:0] expOp2();
    if (!model.valid) return 0;
    return model.bsel ? model.imm : operandValue(model.rs2, model.r2d);
  endfunction

  task automatic compareAll(input string phase);
    checkOutput({phase, ".stall"},  32'(stall_o),       32'(expStall()));
    checkOutput({phase, ".valid"},  32'(ex_valid_o),    32'(model.valid));
    checkOutput({phase, ".regwr"},  32'(ex_regwrite_o), 32'(model.rw));
    checkOutput({phase, ".memrd"},  32'(ex_memread_o),  32'(model.mr));
    checkOutput({phase, ".rd"},     32'(ex_rd_o),       32'(model.rd));
    checkOutput({phase, ".ctrl"},   32'(ALUctrl_o),     model.valid ? 32'(model.ctrl) : 32'd0);
    checkOutput({phase, ".op1"},    ALUop1_o,           expOp1());
    checkOutput({phase, ".op2"},    ALUop2_o,           expOp2());
    checkOutput({phase, ".store"},  ex_store_data_o,    operandValue(model.rs2, model.r2d));
  endtask

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic runCycle(input string phase);
    modelEntry_t nxt;
    bit stallNow;
    #1;
    compareAll(phase);
    stallNow = expStall();
    nxt = model;
    if (flush_i || (!hold_i && stallNow)) begin
      nxt.valid = 0;
      nxt.rw = 0;
      nxt.mr = 0;
    end else if (!hold_i) begin
      nxt = '{valid: id_valid_i, pc: id_pc_i, imm: id_imm_i, r1d: id_rs1_data_i,
              r2d: id_rs2_data_i, rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i,
              asel: id_asel_i, bsel: id_bsel_i, ctrl: id_aluctrl_i,
              rw: id_regwrite_i && id_valid_i, mr: id_memread_i && id_valid_i};
    end
    @(posedge clk_i);
    model = nxt;
    @(negedge clk_i);
  endtask

  task automatic setIdle();
    id_valid_i = 0; id_pc_i = 0; id_imm_i = 0; id_rs1_data_i = 0; id_rs2_data_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0; id_asel_i = 0; id_bsel_i = 0;
    id_aluctrl_i = 0; id_regwrite_i = 0; id_memread_i = 0;
    hold_i = 0; flush_i = 0;
    mem_rd_i = 0; mem_regwrite_i = 0; mem_result_i = 0;
    wb_rd_i = 0; wb_regwrite_i = 0; wb_data_i = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] r1d, input logic [31:0] r2d,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [1:0] asel, input logic bsel, input logic [3:0] ctrl,
                               input logic rw, input logic mr);
    id_valid_i = 1; id_pc_i = pc; id_imm_i = imm; id_rs1_data_i = r1d; id_rs2_data_i = r2d;
    id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd; id_asel_i = asel; id_bsel_i = bsel;
    id_aluctrl_i = ctrl; id_regwrite_i = rw; id_memread_i = mr;
  endtask

  // Reset asserted in the middle of a cycle must clear everything without waiting for a clock.
  task automatic doReset(input string phase);
    #3;
    rst_ni = 0;
    model = emptyEntry();
    #1;
    compareAll(phase);
    checkOutput({phase, ".op1zero"}, ALUop1_o, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  initial begin
    setIdle();
    model = emptyEntry();
    rst_ni = 0;
    id_valid_i = 1; id_rs1_i = 5'd3; mem_rd_i = 5'd3; mem_regwrite_i = 1;
    #2;
    compareAll("rst");
    checkOutput("rst.stallzero", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1;
    setIdle();

    // add: x1=5, x2=7 reaches the ALU one cycle later
    applyStimulus(32'h100, 32'h9, 32'd5, 32'd7, 5'd1, 5'd2, 5'd5, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0);
    runCycle("add.id");
    setIdle();
    #1;
    checkOutput("add.op1", ALUop1_o, 32'd5);
    checkOutput("add.op2", ALUop2_o, 32'd7);
    checkOutput("add.ctrl", 32'(ALUctrl_o), 32'd0);
    checkOutput("add.valid", 32'(ex_valid_o), 32'd1);
    runCycle("add.ex");

    // rs1=x3 with EX/MEM and MEM/WB both writing x3
    applyStimulus(32'h200, 32'h0, 32'hAAAA, 32'h0, 5'd3, 5'd0, 5'd9, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0);
    runCycle("fwd.id");
    setIdle();
    mem_rd_i = 5'd3; mem_regwrite_i = 1; mem_result_i = 32'h10;
    wb_rd_i = 5'd3; wb_regwrite_i = 1; wb_data_i = 32'h20;
    #1;
`ifdef EX_OPERAND_FORWARD_EN
    checkOutput("fwd.mem", ALUop1_o, 32'h10);
`else
    checkOutput("fwd.mem", ALUop1_o, 32'hAAAA);
`endif
    mem_regwrite_i = 0;
    #1;
`ifdef EX_OPERAND_FORWARD_EN
    checkOutput("fwd.wb", ALUop1_o, 32'h20);
`else
    checkOutput("fwd.wb", ALUop1_o, 32'hAAAA);
`endif
    runCycle("fwd.ex");
    setIdle();

    // load to x4 followed by a reader of x4
    applyStimulus(32'h300, 32'h4, 32'h1000, 32'h0, 5'd1, 5'd0, 5'd4, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b1);
    runCycle("lu.ld");
    applyStimulus(32'h304, 32'h0, 32'h1, 32'h2, 5'd4, 5'd2, 5'd6, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b0);
    #1;
    checkOutput("lu.stall", 32'(stall_o), 32'd1);
    runCycle("lu.bub");
    checkOutput("lu.bubble", 32'(ex_valid_o), 32'd0);
    checkOutput("lu.released", 32'(stall_o), 32'd0);
    runCycle("lu.iss");
    checkOutput("lu.issued", 32'(ex_valid_o), 32'd1);
    checkOutput("lu.rd", 32'(ex_rd_o), 32'd6);
    setIdle();

    // flush overrides a pending load-use stall
    applyStimulus(32'h400, 32'h4, 32'h1000, 32'h0, 5'd1, 5'd0, 5'd4, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b1);
    runCycle("fl.ld");
    applyStimulus(32'h404, 32'h0, 32'h1, 32'h2, 5'd4, 5'd2, 5'd6, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b0);
    flush_i = 1;
    #1;
    checkOutput("fl.stall", 32'(stall_o), 32'd0);
    runCycle("fl.cyc");
    setIdle();
    #1;
    checkOutput("fl.valid", 32'(ex_valid_o), 32'd0);

    // hold freezes the entry for three cycles, then reset lands mid-hold
    applyStimulus(32'h500, 32'h77, 32'h1, 32'h2, 5'd1, 5'd2, 5'd7, 2'd1, 1'b1, 4'b0101, 1'b1, 1'b0);
    runCycle("hd.id");
    heldOp1 = 32'h500;
    heldOp2 = 32'h77;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h600 + 32'(i), 32'h80 + 32'(i), 32'h9, 32'h9, 5'd2, 5'd3, 5'd8,
                    2'd0, 1'b0, 4'b1111, 1'b1, 1'b0);
      hold_i = 1;
      #1;
      checkOutput("hd.op1", ALUop1_o, heldOp1);
      checkOutput("hd.op2", ALUop2_o, heldOp2);
      checkOutput("hd.ctrl", 32'(ALUctrl_o), 32'd5);
      runCycle("hd.cyc");
    end
    doReset("hd.rst");
    setIdle();

    // x0 is never forwarded even when a stage claims to write it
    applyStimulus(32'h700, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 2'd2, 1'b0, 4'b0011, 1'b1, 1'b0);
    runCycle("x0.id");
    setIdle();
    mem_rd_i = 5'd0; mem_regwrite_i = 1; mem_result_i = 32'hFF;
    wb_rd_i = 5'd0; wb_regwrite_i = 1; wb_data_i = 32'hEE;
    #1;
    checkOutput("x0.op2", ALUop2_o, 32'd0);
    checkOutput("x0.store", ex_store_data_o, 32'd0);
    runCycle("x0.ex");

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 137 == 136) begin
        doReset("rnd.rst");
      end
      id_valid_i     = ($urandom_range(0, 3) != 0);
      id_pc_i        = $urandom;
      id_imm_i       = $urandom;
      id_rs1_data_i  = $urandom;
      id_rs2_data_i  = $urandom;
      id_rs1_i       = 5'($urandom_range(0, 3));
      id_rs2_i       = 5'($urandom_range(0, 3));
      id_rd_i        = 5'($urandom_range(0, 3));
      id_asel_i      = 2'($urandom_range(0, 3));
      id_bsel_i      = 1'($urandom_range(0, 1));
      id_aluctrl_i   = 4'($urandom_range(0, 15));
      id_regwrite_i  = id_valid_i && ($urandom_range(0, 1) == 1);
      id_memread_i   = id_valid_i && ($urandom_range(0, 2) == 0);
      hold_i         = ($urandom_range(0, 6) == 0);
      flush_i        = ($urandom_range(0, 9) == 0);
      mem_rd_i       = 5'($urandom_range(0, 3));
      mem_regwrite_i = 1'($urandom_range(0, 1));
      mem_result_i   = $urandom;
      wb_rd_i        = 5'($urandom_range(0, 3));
      wb_regwrite_i  = 1'($urandom_range(0, 1));
      wb_data_i      = $urandom;
      runCycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
